// File: rtl/mem_map_pkg.sv
// Shared memory-map constants for the data-memory responder:
// default MMIO addresses, result window and tohost encoding.
package mem_map_pkg;

  localparam logic [31:0] DEF_RESULT_BASE = 32'h0000_0100;
  localparam int          DEF_NUM_RESULTS = 13;
  localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_1000;
  localparam logic [31:0] DEF_CYCLE_ADDR  = 32'h0000_1004;

  // tohost word layout: bit0 = done, [31:1] = exit code (0 = pass)
  localparam int HALT_DONE_BIT = 0;

  typedef enum logic [1:0] {
    REGION_NONE,
    REGION_RAM,
    REGION_TOHOST,
    REGION_CYCLE
  } region_e;

  function automatic logic [31:0] tohost_word(input logic [30:0] code, input logic done);
    return {code, done};
  endfunction

endpackage

// File: rtl/result_scoreboard.sv
// Tracks which result slots have been written and whether each holds a
// nonzero (failing) word; counts and all_reported lag the slot bits by one cycle.
module result_scoreboard #(
  parameter int NUM_RESULTS = 13,
  parameter int SW          = 4,
  parameter int CW          = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   slot_wr,
  input  logic [SW-1:0]          slot_idx,
  input  logic [31:0]            slot_word,
  output logic [NUM_RESULTS-1:0] results_valid,
  output logic [NUM_RESULTS-1:0] results_fail,
  output logic [CW-1:0]          pass_count,
  output logic [CW-1:0]          fail_count,
  output logic                   all_reported
);

  logic [CW-1:0] pass_next;
  logic [CW-1:0] fail_next;

  always_comb begin
    pass_next = '0;
    fail_next = '0;
    for (int k = 0; k < NUM_RESULTS; k++) begin
      pass_next = pass_next + CW'(results_valid[k] & ~results_fail[k]);
      fail_next = fail_next + CW'(results_valid[k] & results_fail[k]);
    end
  end

  // A rewrite simply overwrites the slot's fail bit, so counts never double up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      results_valid <= '0;
      results_fail  <= '0;
      pass_count    <= '0;
      fail_count    <= '0;
      all_reported  <= 1'b0;
    end else begin
      if (slot_wr) begin
        results_valid[slot_idx] <= 1'b1;
        results_fail[slot_idx]  <= |slot_word;
      end
      pass_count   <= pass_next;
      fail_count   <= fail_next;
      all_reported <= &results_valid;
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Memory end of the CPU data port: byte-enable RAM with combinational read,
// tohost halt register, cycle counter and a result-slot scoreboard.
module dmem_mmio_responder
  import mem_map_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] RESULT_BASE = DEF_RESULT_BASE,
  parameter int          NUM_RESULTS = DEF_NUM_RESULTS,
  parameter logic [31:0] TOHOST_ADDR = DEF_TOHOST_ADDR,
  parameter logic [31:0] CYCLE_ADDR  = DEF_CYCLE_ADDR,
  parameter int          CW          = $clog2(NUM_RESULTS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            d_mem_addr,
  input  logic [31:0]            d_mem_wdata,
  input  logic [3:0]             d_mem_wen,
  output logic [31:0]            d_mem_rdata,
  output logic [NUM_RESULTS-1:0] results_valid,
  output logic [NUM_RESULTS-1:0] results_fail,
  output logic [CW-1:0]          pass_count,
  output logic [CW-1:0]          fail_count,
  output logic                   all_reported,
  output logic                   halt,
  output logic [30:0]            halt_code,
  output logic                   addr_err,
  output logic [31:0]            cycle_count
);

  localparam int          AW           = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int          SW           = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1;
  localparam logic [31:0] RAM_BYTES    = 32'(4 * MEM_WORDS);
  localparam logic [31:0] RESULT_BYTES = 32'(4 * NUM_RESULTS);
  localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

  logic [31:0]   mem [MEM_WORDS];
  region_e       region;
  logic [AW-1:0] word_idx;
  logic [31:0]   ram_word;
  logic [31:0]   merged_word;
  logic [31:0]   slot_off;
  logic [SW-1:0] slot_idx;
  logic          wr_en;
  logic          slot_wr;
  logic          halt_set;

  assign word_idx = d_mem_addr[AW+1:2];
  assign ram_word = mem[word_idx];

  // The full address is compared so bits [1:0] are masked rather than dropped.
  always_comb begin
    region = REGION_NONE;
    if (d_mem_addr < RAM_BYTES)
      region = REGION_RAM;
    else if ((d_mem_addr & WORD_MASK) == (TOHOST_ADDR & WORD_MASK))
      region = REGION_TOHOST;
    else if ((d_mem_addr & WORD_MASK) == (CYCLE_ADDR & WORD_MASK))
      region = REGION_CYCLE;
  end

  always_comb begin
    d_mem_rdata = 32'h0;
    case (region)
      REGION_RAM:    d_mem_rdata = ram_word;
      REGION_TOHOST: d_mem_rdata = tohost_word(halt_code, halt);
      REGION_CYCLE:  d_mem_rdata = cycle_count;
      default:       d_mem_rdata = 32'h0;
    endcase
  end

  always_comb begin
    merged_word = ram_word;
    for (int i = 0; i < 4; i++)
      if (d_mem_wen[i]) merged_word[8*i +: 8] = d_mem_wdata[8*i +: 8];
  end

  // Writes are suppressed during reset and once the program has halted.
  assign wr_en    = rst_n && (d_mem_wen != 4'b0000) && !halt;
  assign slot_off = d_mem_addr - RESULT_BASE;
  assign slot_idx = slot_off[SW+1:2];
  assign slot_wr  = wr_en && (region == REGION_RAM) &&
                    (d_mem_addr >= RESULT_BASE) && (slot_off < RESULT_BYTES);
  assign halt_set = wr_en && (region == REGION_TOHOST) && d_mem_wdata[HALT_DONE_BIT];

  always_ff @(posedge clk) begin
    if (wr_en && region == REGION_RAM)
      mem[word_idx] <= merged_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halt        <= 1'b0;
      halt_code   <= '0;
      addr_err    <= 1'b0;
      cycle_count <= '0;
    end else begin
      addr_err <= wr_en && (region == REGION_NONE);
      if (halt_set) begin
        halt      <= 1'b1;
        halt_code <= d_mem_wdata[31:1];
      end
      if (!halt && !halt_set)
        cycle_count <= cycle_count + 32'd1;
    end
  end

  result_scoreboard #(
    .NUM_RESULTS(NUM_RESULTS),
    .SW         (SW),
    .CW         (CW)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .slot_wr      (slot_wr),
    .slot_idx     (slot_idx),
    .slot_word    (merged_word),
    .results_valid(results_valid),
    .results_fail (results_fail),
    .pass_count   (pass_count),
    .fail_count   (fail_count),
    .all_reported (all_reported)
  );

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: read expectations go through a queue,
// status outputs are compared against a small slot model.
module tb_dmem_mmio_responder;

  localparam int          NR = 13;
  localparam int          CW = $clog2(NR + 1);
  localparam logic [31:0] RB = 32'h0000_0100;
  localparam logic [31:0] TH = 32'h0000_1000;
  localparam logic [31:0] CY = 32'h0000_1004;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   d_mem_addr;
  logic [31:0]   d_mem_wdata;
  logic [3:0]    d_mem_wen;
  logic [31:0]   d_mem_rdata;
  logic [NR-1:0] results_valid;
  logic [NR-1:0] results_fail;
  logic [CW-1:0] pass_count;
  logic [CW-1:0] fail_count;
  logic          all_reported;
  logic          halt;
  logic [30:0]   halt_code;
  logic          addr_err;
  logic [31:0]   cycle_count;

  always #5 clk = ~clk;

  dmem_mmio_responder #(
    .MEM_WORDS  (1024),
    .RESULT_BASE(RB),
    .NUM_RESULTS(NR),
    .TOHOST_ADDR(TH),
    .CYCLE_ADDR (CY)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .d_mem_addr   (d_mem_addr),
    .d_mem_wdata  (d_mem_wdata),
    .d_mem_wen    (d_mem_wen),
    .d_mem_rdata  (d_mem_rdata),
    .results_valid(results_valid),
    .results_fail (results_fail),
    .pass_count   (pass_count),
    .fail_count   (fail_count),
    .all_reported (all_reported),
    .halt         (halt),
    .halt_code    (halt_code),
    .addr_err     (addr_err),
    .cycle_count  (cycle_count)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [NR-1:0] model_valid;
  logic [NR-1:0] model_fail;
  logic [31:0]   c0;
  logic [31:0]   c_halt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wen);
    @(negedge clk);
    d_mem_addr  = addr;
    d_mem_wdata = wdata;
    d_mem_wen   = wen;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(32'h0, 32'h0, 4'b0000);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed %h expected none", d_mem_rdata);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, d_mem_rdata, e.data);
    end
  endtask

  task automatic expectRead(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    @(negedge clk);
    d_mem_addr = addr;
    d_mem_wen  = 4'b0000;
    exp_q.push_back('{tag, exp});
    #1;
    checkOutput();
  endtask

  task automatic scoreWrite(input int k, input logic [31:0] word);
    applyStimulus(RB + 32'(4 * k), word, 4'b1111);
    model_valid[k] = 1'b1;
    model_fail[k]  = (word != 32'h0);
  endtask

  task automatic checkScore(input string tag);
    check({tag, "_valid"}, 32'(results_valid), 32'(model_valid));
    check({tag, "_fail"},  32'(results_fail),  32'(model_fail));
    check({tag, "_pass_cnt"}, 32'(pass_count), 32'($countones(model_valid & ~model_fail)));
    check({tag, "_fail_cnt"}, 32'(fail_count), 32'($countones(model_valid & model_fail)));
    check({tag, "_all"}, 32'(all_reported), 32'(&model_valid));
  endtask

  task automatic checkAllClear(input string tag);
    check({tag, "_valid"}, 32'(results_valid), 32'h0);
    check({tag, "_fail"},  32'(results_fail),  32'h0);
    check({tag, "_pass_cnt"}, 32'(pass_count), 32'h0);
    check({tag, "_fail_cnt"}, 32'(fail_count), 32'h0);
    check({tag, "_all"}, 32'(all_reported), 32'h0);
    check({tag, "_halt"}, 32'(halt), 32'h0);
    check({tag, "_code"}, 32'(halt_code), 32'h0);
    check({tag, "_addr_err"}, 32'(addr_err), 32'h0);
    check({tag, "_cycle"}, cycle_count, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    d_mem_addr  = 32'h0;
    d_mem_wdata = 32'h0;
    d_mem_wen   = 4'b0000;
    model_valid = '0;
    model_fail  = '0;

    repeat (2) @(negedge clk);
    checkAllClear("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("cycle_start", cycle_count, 32'd1);

    // Byte lanes
    applyStimulus(32'h20, 32'hAABB_CCDD, 4'b1111);
    expectRead(32'h20, 32'hAABB_CCDD, "full_word");
    applyStimulus(32'h20, 32'h1122_3344, 4'b0101);
    expectRead(32'h20, 32'hAA22_CC44, "byte_lanes");
    applyStimulus(32'h22, 32'h9900_0000, 4'b1000);
    expectRead(32'h21, 32'h9922_CC44, "low_bits_ignored");
    applyStimulus(32'h20, 32'hAABB_CCDD, 4'b1000);
    expectRead(32'h20, 32'hAA22_CC44, "lane3_restore");

    // Scoreboard fill: slots 0..11 pass, slot 12 fails
    for (int k = 0; k < 12; k++) scoreWrite(k, 32'h0);
    scoreWrite(12, 32'h1);
    idle(1);
    check("valid_before_counts", 32'(results_valid), 32'h1FFF);
    check("fail_cnt_lag", 32'(fail_count), 32'd0);
    check("all_reported_lag", 32'(all_reported), 32'd0);
    idle(1);
    check("fill_pass_cnt", 32'(pass_count), 32'd12);
    check("fill_fail_cnt", 32'(fail_count), 32'd1);
    check("fill_all", 32'(all_reported), 32'd1);
    check("fill_fail_vec", 32'(results_fail), 32'h1000);
    expectRead(RB + 32'd48, 32'h1, "slot12_read");

    // Rewrite slot 3
    scoreWrite(3, 32'h1);
    idle(2);
    checkScore("rewrite_fail");
    scoreWrite(3, 32'h0);
    idle(2);
    checkScore("rewrite_pass");
    check("slot3_valid", 32'(results_valid[3]), 32'd1);

    // Out-of-range write and unmapped reads
    applyStimulus(32'h2000, 32'hDEAD_BEEF, 4'b1111);
    idle(1);
    check("addr_err_pulse", 32'(addr_err), 32'd1);
    idle(1);
    check("addr_err_clear", 32'(addr_err), 32'd0);
    expectRead(32'h2000, 32'h0, "oor_read");
    expectRead(32'h1008, 32'h0, "unmapped_read");
    check("read_no_addr_err", 32'(addr_err), 32'd0);

    // Last RAM word and ignored MMIO writes
    applyStimulus(32'hFFC, 32'h0BAD_F00D, 4'b1111);
    expectRead(32'hFFC, 32'h0BAD_F00D, "last_word");
    check("last_word_no_err", 32'(addr_err), 32'd0);
    applyStimulus(CY, 32'h0, 4'b1111);
    idle(1);
    check("cycle_write_no_err", 32'(addr_err), 32'd0);
    @(negedge clk);
    d_mem_addr = CY;
    d_mem_wen  = 4'b0000;
    #1;
    c0 = d_mem_rdata;
    expectRead(CY, c0 + 32'd1, "cycle_step");
    applyStimulus(TH, 32'hFFFF_FFFE, 4'b1111);
    idle(1);
    check("tohost_bit0_clear", 32'(halt), 32'd0);
    expectRead(TH, 32'h0, "tohost_idle_read");

    // Reset mid-run with a write in the reset cycle
    applyStimulus(32'h24, 32'hCAFE_F00D, 4'b1111);
    @(negedge clk);
    rst_n       = 1'b0;
    d_mem_addr  = 32'h24;
    d_mem_wdata = 32'h1234_5678;
    d_mem_wen   = 4'b1111;
    @(negedge clk);
    rst_n       = 1'b1;
    d_mem_addr  = 32'h0;
    d_mem_wen   = 4'b0000;
    checkAllClear("midrun_reset");
    model_valid = '0;
    model_fail  = '0;
    expectRead(32'h20, 32'hAA22_CC44, "ram_kept");
    check("cycle_restart", cycle_count, 32'd1);
    expectRead(32'h24, 32'hCAFE_F00D, "reset_write_dropped");
    for (int k = 0; k < 5; k++) scoreWrite(k, 32'h0);
    scoreWrite(4, 32'h0000_0100);
    idle(2);
    checkScore("restart");

    // Halt and freeze
    applyStimulus(TH, 32'h0000_0007, 4'b1111);
    idle(1);
    check("halt_set", 32'(halt), 32'd1);
    check("halt_code", 32'(halt_code), 32'd3);
    expectRead(TH, 32'h0000_0007, "tohost_read");
    c_halt = cycle_count;
    applyStimulus(32'h20, 32'h5555_5555, 4'b1111);
    applyStimulus(32'h2000, 32'h1, 4'b1111);
    applyStimulus(TH, 32'h0000_000F, 4'b1111);
    applyStimulus(RB, 32'h1, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("frozen_addr_err", 32'(addr_err), 32'd0);
    end
    check("cycle_frozen", cycle_count, c_halt);
    check("halt_code_kept", 32'(halt_code), 32'd3);
    checkScore("halt_score");
    expectRead(32'h20, 32'hAA22_CC44, "ram_frozen");
    expectRead(CY, c_halt, "cycle_read_frozen");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Synthesizable responder for the CPU data-memory port (d_mem_*); it is the memory end of the interface `cpu_top` initiates.
- Provides byte-enable word RAM with combinational read, which the CPU requires for same-cycle load data.
- Adds a test-result scoreboard over the result window, a tohost-style halt register and a free-running cycle counter.
- Replaces behavioural data-memory models in benches and FPGA builds; status outputs drive LEDs or the bench's pass/fail check.

Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words; byte range 0 .. 4*MEM_WORDS-1.
- RESULT_BASE, 32'h0000_0100, byte address of result slot 0.
- NUM_RESULTS, 13, number of result slots; slot k is at RESULT_BASE+4k.
- TOHOST_ADDR, 32'h0000_1000, halt register address; must lie outside RAM.
- CYCLE_ADDR, 32'h0000_1004, read-only cycle counter address; must lie outside RAM.
- CW, $clog2(NUM_RESULTS+1), width of the pass/fail counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- d_mem_addr  in  32  byte address; bits [1:0] ignored, word index = addr>>2.
- d_mem_wdata  in  32  store data, lanes already aligned by the CPU.
- d_mem_wen  in  4  byte-lane write enables; 4'b0000 = no write.
- d_mem_rdata  out  32  combinational read data.
- results_valid  out  NUM_RESULTS  slot k has been written since reset.
- results_fail  out  NUM_RESULTS  slot k's last written word is nonzero.
- pass_count  out  CW  number of valid slots with value 0.
- fail_count  out  CW  number of valid slots with nonzero value.
- all_reported  out  1  all slots valid.
- halt  out  1  tohost written with bit0=1.
- halt_code  out  31  wdata[31:1] captured at halt; 0 = pass.
- addr_err  out  1  one-cycle pulse on an out-of-range write.
- cycle_count  out  32  cycles since reset.

Behaviour:
- Reset, synchronous on posedge with rst_n=0: all outputs and control registers go to 0. RAM contents are not reset.
- Read path (combinational, zero latency):
  - In-RAM address: return the RAM word.
  - TOHOST_ADDR: return {halt_code, halt}.
  - CYCLE_ADDR: return cycle_count.
  - Any other address: return 32'h0. Reads never raise addr_err.
- Write path: on posedge with rst_n=1, wen!=0 and halt=0.
  - In-RAM address: write only the enabled byte lanes. New data is visible on reads from the next cycle.
  - Write to CYCLE_ADDR: ignored.
  - Write to TOHOST_ADDR with wdata[0]=1: set halt and capture halt_code. A write with wdata[0]=0 is ignored.
  - Write to any other address: no state change; addr_err=1 on the following cycle only.
- Halt freeze: once halt=1, all writes are ignored and no further addr_err pulses occur. Reads still serve; cycle_count stops. Only reset clears halt.
- Cycle counter: cycle_count increments every cycle while halt=0 and wraps 32'hFFFF_FFFF -> 0. It holds its value in the cycle in which halt is set.
- Scoreboard: a RAM write to slot k (any nonzero wen) behaves as follows.
  - Set results_valid[k].
  - Set results_fail[k] = (byte-merged new word != 0).
  - Outputs update on the same edge as the RAM write, so they are visible the next cycle.
  - A rewrite of a slot replaces its pass/fail state; counts are never double-counted.
  - pass_count = popcount(valid & ~fail); fail_count = popcount(valid & fail). Both are registered, so they update one cycle after the slot bits.
  - all_reported is registered with the same one-cycle lag.
  - Addresses between slots are not possible because addr[1:0] is ignored. Addresses beyond slot NUM_RESULTS-1 are ordinary RAM.
- Reset mid-run: a write in the reset cycle is dropped, and the scoreboard restarts from empty.

Decomposition:
- Shared package `mem_map_pkg`: RESULT_BASE, NUM_RESULTS, TOHOST_ADDR and CYCLE_ADDR defaults, and the halt encoding (bit0 = done, [31:1] = code).
- One sub-module, `result_scoreboard`:
  - Inputs: slot write strobe, slot index, merged word.
  - Outputs: valid/fail vectors, counts, all_reported.
- RAM, address decode, halt register and counter stay in the top module.

Test Plan:
- Byte lanes: write 32'hAABBCCDD to 0x20 with wen=4'b1111, then 32'h11223344 with wen=4'b0101 -> read 0x20 = 32'hAA22CC44 one cycle later.
- Scoreboard: write 0 to slots 0..11 and 1 to slot 12 -> pass_count=12, fail_count=1, all_reported=1, results_fail=13'h1000.
- Rewrite: write 1 to slot 3, then 0 to slot 3 -> fail_count 1 -> 0, pass_count 0 -> 1, results_valid[3] stays 1.
- Halt: write 32'h0000_0007 to TOHOST_ADDR -> halt=1, halt_code=3. A later write to 0x20 leaves RAM unchanged, and cycle_count is frozen across 10 cycles.
- Out of range and counter: write to 0x2000 -> addr_err pulses for exactly 1 cycle, and a read of 0x2000 returns 0. Read CYCLE_ADDR on two consecutive cycles -> values differ by 1.
- Reset mid-run: slots 0..4 valid, assert rst_n=0 for one cycle -> all outputs 0, cycle_count restarts at 0, RAM word at 0x20 keeps its value.
